// File: rtl/serdes_word_serializer.sv
// Transmit-side test-word source for single-pin SERDES loopback: generates PRBS7/counter/training/fixed
// words and shifts them out MSB-first in SDR or DDR with a matching bit clock and a per-word strobe.
module serdes_word_serializer #(
  parameter int unsigned WIDTH   = 8,
  parameter string       MODE    = "SDR",
  parameter logic [6:0]  SEED    = 7'h7F,
  parameter logic [7:0]  PATTERN = 8'hA5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       PAT_SEL,
  input  logic             ERR_INJ,
  output logic             O_STB,
  output logic [WIDTH-1:0] O_DAT,
  output logic             O_BUSY,
  output logic             S_CLK,
  output logic             S_DAT
);

  localparam bit               IS_DDR   = (MODE == "DDR");
  localparam logic [6:0]       SEED_EFF = (SEED == 7'h00) ? 7'h01 : SEED;
  localparam logic [2:0]       LAST_BIT = 3'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TRAIN    = {(WIDTH/2){2'b10}};
  localparam logic [WIDTH-1:0] FIXED    = PATTERN[WIDTH-1:0];

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ph;
  logic [2:0]       bit_idx;
  logic [6:0]       lfsr;
  logic [6:0]       lfsr_nxt;
  logic [WIDTH-1:0] cnt;
  logic             err_pend;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] prbs_word;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] tx_word;
  logic             bnd;
  logic             last;
  logic             load;

  // ph is the S_CLK phase the next edge will present; SDR bits only start on its low phase.
  assign bnd  = IS_DDR | ~ph;
  assign last = (bit_idx == LAST_BIT);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bnd && EN) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (bnd && last) begin
          if (EN) load = 1'b1;
          else    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One word's worth of LFSR steps, first feedback bit lands in the MSB.
  always_comb begin
    lfsr_nxt  = lfsr;
    prbs_word = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      prbs_word[i] = lfsr_nxt[6] ^ lfsr_nxt[5];
      lfsr_nxt     = {lfsr_nxt[5:0], prbs_word[i]};
    end
    case (PAT_SEL)
      2'd0:    word = prbs_word;
      2'd1:    word = cnt;
      2'd2:    word = TRAIN;
      default: word = FIXED;
    endcase
    tx_word = word ^ {{(WIDTH-1){1'b0}}, err_pend};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ph       <= 1'b0;
      bit_idx  <= '0;
      lfsr     <= SEED_EFF;
      cnt      <= '0;
      err_pend <= 1'b0;
      O_STB    <= 1'b0;
      O_DAT    <= '0;
      O_BUSY   <= 1'b0;
      S_CLK    <= 1'b0;
      S_DAT    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ph       <= ~ph;
      S_CLK    <= ph;
      O_STB    <= load;
      // A pulse arriving in the load cycle itself belongs to the following word.
      err_pend <= load ? ERR_INJ : (err_pend | ERR_INJ);
      if (load) begin
        O_DAT   <= word;
        O_BUSY  <= 1'b1;
        S_DAT   <= tx_word[WIDTH-1];
        bit_idx <= '0;
        if (PAT_SEL == 2'd0) lfsr <= lfsr_nxt;
        if (PAT_SEL == 2'd1) cnt  <= cnt + 1'b1;
      end else if (state == SEND && bnd) begin
        if (last) begin
          O_BUSY <= 1'b0;
          S_DAT  <= 1'b0;
        end else begin
          S_DAT   <= shreg[WIDTH-1];
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (load)                    shreg <= tx_word << 1;
    else if (state == SEND && bnd) shreg <= shreg << 1;
  end

endmodule

// File: doc/serdes_word_serializer.md
Name: serdes_word_serializer

Overview:
- Transmit-side source for single-pin SERDES loopback tests; counterpart of the deserializing receive path.
- Generates test words (PRBS7, counter, training or fixed pattern) and serializes them MSB-first onto one data pin, in SDR or DDR.
- Produces the matching bit clock, plus a per-word strobe and copy of each word for the comparator.
- Supports deliberate error injection to prove the comparison chain detects faults.

Parameters:
- WIDTH, 8, word width; legal 2..8, even.
- MODE, "SDR", "SDR" or "DDR" serialization.
- SEED, 7'h7F, PRBS7 reset state; a SEED of 0 is replaced by 7'h01.
- PATTERN, 8'hA5, fixed word for PAT_SEL=3; low WIDTH bits used.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  run enable; sampled at word boundaries.
- PAT_SEL  input  2  pattern: 0 PRBS7, 1 counter, 2 training, 3 PATTERN; sampled at word boundaries.
- ERR_INJ  input  1  one-cycle request to corrupt one transmitted word.
- O_STB  output  1  one-cycle pulse marking the first serial bit of a word on S_DAT.
- O_DAT  output  WIDTH  uncorrupted word being sent; valid while O_STB=1, held until next O_STB.
- O_BUSY  output  1  high while a word is being serialized.
- S_CLK  output  1  serial bit clock.
- S_DAT  output  1  serial data to OBUFT.

Behaviour:
- Reset: all outputs 0; LFSR=SEED (0 mapped to 7'h01); counter=0; err_pending=0; bit index=0; phase=0.
- All outputs are registered.
- Bit period:
  - SDR: 2 CLK cycles; S_CLK low in cycle 0 of each bit, high in cycle 1 (0,1,0,1...). S_DAT changes only at S_CLK falling (phase 0).
  - DDR: 1 CLK cycle per bit; S_CLK toggles every CLK (0,1,0,1...). S_DAT changes every cycle, so both S_CLK edges carry data.
- S_CLK runs whenever RST=0, including idle.
- Word period: 2*WIDTH cycles (SDR) or WIDTH cycles (DDR). Words are back-to-back with no gap while EN=1.
- States:
  - IDLE: S_DAT=0, O_BUSY=0. Moves to SEND at the next bit boundary with EN=1 (SDR: phase 0). First word leaves in the cycle after RST falls if EN=1.
  - SEND: shifts WIDTH bits MSB-first.
  - After the last bit: if EN=1, load next word and stay in SEND; else go to IDLE.
  - EN falling mid-word never truncates a word.
- On word load:
  - O_STB=1 and S_DAT=new MSB in the same cycle; O_DAT updates in that cycle.
  - O_BUSY=1 from load through the last bit.
- PRBS7:
  - Per bit: f=s[6]^s[5]; s<={s[5:0],f}; bit=f.
  - A word consumes WIDTH consecutive f values, first f is the MSB; compute with an unrolled loop.
  - LFSR advances only when a PRBS word is loaded.
- Counter: word=cnt, then cnt+1 mod 2^WIDTH; advances only on counter-word loads.
- Training: {WIDTH/2{2'b10}} (8'hAA for WIDTH=8).
- Error injection:
  - ERR_INJ sets err_pending; repeated pulses before consumption are one request.
  - At the next word load with err_pending=1, that word's LSB is inverted on S_DAT only. O_DAT stays correct. err_pending clears.
  - ERR_INJ in the load cycle itself applies to the following word.
- PAT_SEL change mid-word: takes effect at the next load only.
- RST mid-word: everything returns to reset values on the next edge; the partial word is abandoned.

Test Plan:
- WIDTH=8, SDR, SEED=7F, PAT_SEL=0, EN=1 after reset:
  - O_STB at cycle 1 after reset release with O_DAT=8'h02, next O_STB 16 cycles later with 8'h0C.
  - S_DAT samples on S_CLK rising match O_DAT MSB-first.
- DDR, PAT_SEL=1:
  - O_STB every 8 cycles; O_DAT 00,01,02..FF,00 (wrap).
  - S_DAT changes every cycle; S_CLK toggles every cycle.
- PAT_SEL=2, then switch to 3 mid-word:
  - Current word 8'hAA completes on S_DAT.
  - Next O_DAT=8'hA5.
- ERR_INJ pulsed twice mid-word (counter mode, word 8'h10 in flight):
  - Next word O_DAT=8'h11, S_DAT bits 8'h10.
  - Following word bits match O_DAT (single injection only).
- EN dropped at bit 3:
  - Word completes; O_BUSY falls after bit 7; S_DAT=0; S_CLK keeps running.
  - EN re-raised: next PRBS word continues the sequence, no LFSR reset.
- RST asserted at bit 5:
  - Next cycle all outputs 0.
  - After release, first word again 8'h02 (PRBS, SEED=7F).
